// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
//
// Bit-serial subtractor controller. A single one-bit subtract cell (two half
// subtractors plus an OR, borrow chained through a flop) is stepped over WIDTH
// cycles, LSB first, to compute a - b modulo 2^WIDTH.
//
// Optional feature macro: SERIAL_SUB_CMP_EN adds the a_lt_b / a_eq_b outputs
// and the sticky zero-tracking flop behind a_eq_b.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset
//   start   in   request strobe, accepted in IDLE or DONE, ignored in RUN
//   a, b    in   minuend / subtrahend, captured on acceptance
//   busy    out  high while in RUN
//   done    out  one-cycle pulse marking a new result
//   diff    out  registered (a - b) mod 2^WIDTH, changes only at completion
//   borrow  out  final borrow (1 iff a < b unsigned)
//   a_lt_b  out  (SERIAL_SUB_CMP_EN) equals the final borrow
//   a_eq_b  out  (SERIAL_SUB_CMP_EN) 1 iff every difference bit was 0
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one bit processed per edge, LSB first
// DONE  | single cycle, done asserted; start here restarts directly

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_CMP_EN
    ,
    output logic             a_lt_b,
    output logic             a_eq_b
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             accept;
    logic             last_bit;
    logic             ai;
    logic             bi;
    logic             d;
    logic             bout;
`ifdef SERIAL_SUB_CMP_EN
    logic             all_zero;
`endif

    // Subtract cell
    assign ai   = a_sh[0];
    assign bi   = b_sh[0];
    assign d    = ai ^ bi ^ brw;
    assign bout = (~ai & bi) | (~(ai ^ bi) & brw);

    // New bit enters at the MSB; written as a shift/or so WIDTH=1 needs no
    // special-case slicing.
    assign res_nxt  = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = start && (state != S_RUN);

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN:  if (last_bit) state_nxt = S_DONE;
            S_DONE: state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
            brw  <= 1'b0;
        end else if (state == S_RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_nxt;
            brw  <= bout;
            cnt  <= cnt + CW'(1);
            if (last_bit) begin
                diff   <= res_nxt;
                borrow <= bout;
            end
        end
    end

`ifdef SERIAL_SUB_CMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_zero <= 1'b0;
            a_lt_b   <= 1'b0;
            a_eq_b   <= 1'b0;
        end else if (accept) begin
            all_zero <= 1'b1;
        end else if (state == S_RUN) begin
            all_zero <= all_zero & ~d;
            if (last_bit) begin
                a_lt_b <= bout;
                a_eq_b <= all_zero & ~d;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
module tb_serial_subtractor_ctrl;

    localparam int W8 = 8;

    logic          clk;
    logic          rst;

    logic          start8;
    logic [W8-1:0] a8, b8;
    logic          busy8, done8, borrow8;
    logic [W8-1:0] diff8;

    logic          start1;
    logic          a1, b1;
    logic          busy1, done1, borrow1;
    logic          diff1;

`ifdef SERIAL_SUB_CMP_EN
    logic          lt8, eq8, lt1, eq1;
`endif

    int checks   = 0;
    int failures = 0;

    serial_subtractor_ctrl #(.WIDTH(W8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
`ifdef SERIAL_SUB_CMP_EN
        ,
        .a_lt_b (lt8),
        .a_eq_b (eq8)
`endif
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
        .borrow (borrow1)
`ifdef SERIAL_SUB_CMP_EN
        ,
        .a_lt_b (lt1),
        .a_eq_b (eq1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: runs one WIDTH=8 operation and reports what was seen.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] od, output logic ob,
                        output logic olt, output logic oeq,
                        output int lat, output int busy_cnt,
                        output logic done_after, output logic glitch);
        logic [7:0] d0;
        logic       b0;
        lat = -1; busy_cnt = 0; glitch = 1'b0; olt = 1'b0; oeq = 1'b0;
        done_after = 1'b0;
        @(negedge clk);
        a8 = x; b8 = y; start8 = 1'b1;
        d0 = diff8; b0 = borrow8;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        if (busy8) busy_cnt++;
        for (int k = 1; k <= 3 * W8; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = k;
                break;
            end
            if (busy8) busy_cnt++;
            if (diff8 !== d0 || borrow8 !== b0) glitch = 1'b1;
        end
        od = diff8; ob = borrow8;
`ifdef SERIAL_SUB_CMP_EN
        olt = lt8; oeq = eq8;
`endif
        @(posedge clk); #1;
        done_after = done8;
    endtask

    task automatic test_reset;
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
            failures++;
            $display("FAIL reset8 got=%0h exp=0", {busy8, done8, diff8, borrow8});
        end
        checks++;
        if ({busy1, done1, diff1, borrow1} !== 4'd0) begin
            failures++;
            $display("FAIL reset1 got=%0h exp=0", {busy1, done1, diff1, borrow1});
        end
`ifdef SERIAL_SUB_CMP_EN
        checks++;
        if ({lt8, eq8} !== 2'b00) begin
            failures++;
            $display("FAIL reset_cmp got=%0b exp=00", {lt8, eq8});
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ops(input int n_random);
        logic [7:0] xs[$];
        logic [7:0] ys[$];
        logic [7:0] od, exp_d;
        logic       ob, olt, oeq, da, gl, exp_b;
        int         lat, bc;
        xs = '{8'd5, 8'd3, 8'h00, 8'hA5, 8'hFF};
        ys = '{8'd3, 8'd5, 8'h01, 8'hA5, 8'h00};
        for (int i = 0; i < n_random; i++) begin
            xs.push_back(8'($urandom_range(0, 255)));
            ys.push_back((i % 4 == 0) ? xs[xs.size()-1] : 8'($urandom_range(0, 255)));
        end
        foreach (xs[i]) begin
            exp_d = xs[i] - ys[i];
            exp_b = (xs[i] < ys[i]);
            run8(xs[i], ys[i], od, ob, olt, oeq, lat, bc, da, gl);
            checks++;
            if (lat != W8) begin
                failures++;
                $display("FAIL latency a=%0h b=%0h got=%0d exp=%0d", xs[i], ys[i], lat, W8);
            end
            checks++;
            if (od !== exp_d) begin
                failures++;
                $display("FAIL diff a=%0h b=%0h got=%0h exp=%0h", xs[i], ys[i], od, exp_d);
            end
            checks++;
            if (ob !== exp_b) begin
                failures++;
                $display("FAIL borrow a=%0h b=%0h got=%0b exp=%0b", xs[i], ys[i], ob, exp_b);
            end
            checks++;
            if (bc != W8) begin
                failures++;
                $display("FAIL busy_cycles a=%0h b=%0h got=%0d exp=%0d", xs[i], ys[i], bc, W8);
            end
            checks++;
            if (da !== 1'b0) begin
                failures++;
                $display("FAIL done_width a=%0h b=%0h got=%0b exp=0", xs[i], ys[i], da);
            end
            checks++;
            if (gl !== 1'b0) begin
                failures++;
                $display("FAIL output_stable a=%0h b=%0h got=%0b exp=0", xs[i], ys[i], gl);
            end
`ifdef SERIAL_SUB_CMP_EN
            checks++;
            if (olt !== exp_b || oeq !== (xs[i] == ys[i])) begin
                failures++;
                $display("FAIL cmp a=%0h b=%0h got=%0b%0b exp=%0b%0b", xs[i], ys[i],
                         olt, oeq, exp_b, (xs[i] == ys[i]));
            end
`endif
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        lat = -1;
        @(negedge clk);
        a8 = 8'd20; b8 = 8'd6; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd200; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        for (int k = 4; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != W8) begin
            failures++;
            $display("FAIL ignore_latency got=%0d exp=%0d", lat, W8);
        end
        checks++;
        if (diff8 !== 8'd14 || borrow8 !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result got=%0h/%0b exp=e/0", diff8, borrow8);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] x1, y1, x2, y2, e1, e2;
        int         times[$];
        logic [7:0] ds[$];
        logic       no_idle;
        x1 = 8'($urandom_range(0, 255)); y1 = 8'($urandom_range(0, 255));
        x2 = 8'($urandom_range(0, 255)); y2 = 8'($urandom_range(0, 255));
        e1 = x1 - y1; e2 = x2 - y2;
        no_idle = 1'b0;
        @(negedge clk);
        a8 = x1; b8 = y1; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a8 = x2; b8 = y2;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == W8 + 1) begin
                no_idle = busy8 && !done8;
                start8 = 1'b0;
            end
            if (done8) begin
                times.push_back(k);
                ds.push_back(diff8);
            end
        end
        checks++;
        if (!no_idle) begin
            failures++;
            $display("FAIL b2b_no_idle got=%0b exp=1", no_idle);
        end
        checks++;
        if (times.size() != 2) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d exp=2", times.size());
        end else begin
            checks++;
            if (times[1] - times[0] != W8 + 1 || times[0] != W8) begin
                failures++;
                $display("FAIL b2b_spacing got=%0d,%0d exp=%0d,%0d",
                         times[0], times[1], W8, 2 * W8 + 1);
            end
            checks++;
            if (ds[0] !== e1 || ds[1] !== e2) begin
                failures++;
                $display("FAIL b2b_diff got=%0h,%0h exp=%0h,%0h", ds[0], ds[1], e1, e2);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] od;
        logic       ob, olt, oeq, da, gl;
        int         lat, bc;
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd200; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
            failures++;
            $display("FAIL mid_reset got=%0h exp=0", {busy8, done8, diff8, borrow8});
        end
        @(negedge clk);
        rst = 1'b0;
        run8(8'd10, 8'd7, od, ob, olt, oeq, lat, bc, da, gl);
        checks++;
        if (lat != W8 || od !== 8'h03 || ob !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got=%0d/%0h/%0b exp=%0d/3/0", lat, od, ob, W8);
        end
    endtask

    task automatic test_width1;
        logic       x, y, exp_d, exp_b;
        logic [1:0] t;
        for (int i = 0; i < 4; i++) begin
            t = 2'(i);
            x = t[1]; y = t[0];
            t = {1'b0, x} - {1'b0, y};
            exp_d = t[0];
            exp_b = (x < y);
            @(negedge clk);
            a1 = x; b1 = y; start1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            checks++;
            if (busy1 !== 1'b1) begin
                failures++;
                $display("FAIL w1_busy a=%0b b=%0b got=%0b exp=1", x, y, busy1);
            end
            @(posedge clk); #1;
            checks++;
            if (done1 !== 1'b1 || diff1 !== exp_d || borrow1 !== exp_b) begin
                failures++;
                $display("FAIL w1_result a=%0b b=%0b got=%0b%0b%0b exp=1%0b%0b",
                         x, y, done1, diff1, borrow1, exp_d, exp_b);
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_ops(20);
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
